ula_fl_seq: RTL

- Multicycle successor of the processor's combinational float ALU.
- Uses the same custom float format: {s, e, m}. Value = (-1)^s * m * 2^e.
  - e is signed two's complement.
  - m is unsigned and normalized when m[MAN-1]=1.
  - Zero is m=0 with e=100..0.
- Adds a start/busy/done handshake, a MAN-cycle iterative restoring divider, exponent saturation, and sticky exception flags.
- Sits between the processor's operand registers and its accumulator, for configurations where a combinational divider misses timing.

---
 rtl/ula_fl_seq.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/ula_fl_seq.sv
// ula_fl_seq: multicycle float ALU for the {s, e, m} format, value = (-1)^s * m * 2^e.
// Single-cycle ops finish on the accept edge. DIV runs a restoring divider that
// produces one quotient bit per cycle. Results are normalized and their exponent
// saturated, and ovf/unf/dz are sticky.
module ula_fl_seq #(
  parameter int EXP = 8,
  parameter int MAN = 23,
  parameter int ADD = 1,
  parameter int MLT = 1,
  parameter int DIV = 1,
  parameter int CMP = 1,
  parameter int NEG = 1,
  parameter int ABS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [MAN+EXP:0] in1,
  input  logic [MAN+EXP:0] in2,
  input  logic             clr_flags,
  output logic             busy,
  output logic             done,
  output logic [MAN+EXP:0] out,
  output logic             ovf,
  output logic             unf,
  output logic             dz
);
  localparam int W  = MAN + EXP + 1;
  localparam int EW = EXP + 2;
  localparam int CW = $clog2(MAN + 1);

  localparam logic [3:0] OP_NOP = 4'd0, OP_LOAD = 4'd1, OP_ADD = 4'd2, OP_MLT = 4'd3,
                         OP_DIV = 4'd4, OP_NEG = 4'd5, OP_LES = 4'd6, OP_EQU = 4'd7,
                         OP_INV = 4'd8, OP_AND = 4'd9, OP_GRE = 4'd10, OP_OR = 4'd11,
                         OP_ABS = 4'd12;

  localparam logic signed [EW-1:0] E_MAX = EW'((1 << (EXP - 1)) - 1);
  localparam logic signed [EW-1:0] E_MIN = EW'(-(1 << (EXP - 1)));
  localparam logic [W-1:0]   ZERO_W = {1'b0, 1'b1, {(EXP-1){1'b0}}, {MAN{1'b0}}};
  localparam logic [W+1:0]   RES_X  = {2'b00, {W{1'bx}}};

  typedef enum logic [1:0] {IDLE, DIVL, FIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic [MAN:0]      rem_q, rem_d;
  logic [MAN-1:0]    dvd_q, dvd_d, quo_q, quo_d;
  logic [W-1:0]      out_q, out_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, dz_q, dz_d;

  // Sign-extended exponent field of a word
  function automatic logic signed [EW-1:0] exp_of(input logic [W-1:0] x);
    return {{2{x[W-2]}}, x[W-2:MAN]};
  endfunction

  // Leading-zero normalize, then saturate; returns {ovf, unf, word}
  function automatic logic [W+1:0] norm_pack(input logic s, input logic signed [EW-1:0] e,
                                             input logic [MAN-1:0] m);
    int                     lz;
    logic [MAN-1:0]         mn;
    logic signed [EW-1:0]   en;
    lz = MAN;
    for (int i = 0; i < MAN; i++) if (m[i]) lz = MAN - 1 - i;
    mn = m << lz;
    en = e - EW'(lz);
    if (m == '0) return {2'b00, ZERO_W};
    if (en > E_MAX) return {2'b10, s, 1'b0, {(EXP-1){1'b1}}, {MAN{1'b1}}};
    if (en < E_MIN) return {2'b01, ZERO_W};
    return {2'b00, s, en[EXP-1:0], mn};
  endfunction

  logic [3:0]            sel_op;
  logic [W-1:0]          sel_a, sel_b;
  logic                  s1, s2, cbit, dz_ev, qbit;
  logic signed [EW-1:0]  e1, e2, ea;
  logic [EW-1:0]         sh;
  logic [MAN-1:0]        m1, m2, ma, mb, quo_nxt;
  logic signed [MAN+1:0] sa, sb, sum;
  logic [MAN+1:0]        asum;
  logic [2*MAN-1:0]      prod;
  logic [W-1:0]          cres;
  logic [W+1:0]          res;
  logic [MAN:0]          trial, rem_nxt;
  logic                  fin;
  logic                  unused_bits;

  assign unused_bits = ^{asum[MAN+1], asum[0], prod[MAN-1:0], rem_q[MAN]};

  // One restoring-divider step: shift in next dividend bit, subtract if it fits
  always_comb begin
    trial   = {rem_q[MAN-1:0], dvd_q[MAN-1]};
    qbit    = (trial >= {1'b0, b_q[MAN-1:0]});
    rem_nxt = qbit ? (trial - {1'b0, b_q[MAN-1:0]}) : trial;
    quo_nxt = {quo_q[MAN-2:0], qbit};
  end

  // Result unit: live operands while idle, latched operands while dividing
  always_comb begin
    sel_op = (state_q == IDLE) ? op  : op_q;
    sel_a  = (state_q == IDLE) ? in1 : a_q;
    sel_b  = (state_q == IDLE) ? in2 : b_q;
    s1 = sel_a[W-1];  e1 = exp_of(sel_a);  m1 = sel_a[MAN-1:0];
    s2 = sel_b[W-1];  e2 = exp_of(sel_b);  m2 = sel_b[MAN-1:0];
    if (e1 >= e2) begin
      sh = e1 - e2;  ea = e1;  ma = m1;        mb = m2 >> sh;
    end else begin
      sh = e2 - e1;  ea = e2;  ma = m1 >> sh;  mb = m2;
    end
    sa   = s1 ? -{2'b00, ma} : {2'b00, ma};
    sb   = s2 ? -{2'b00, mb} : {2'b00, mb};
    sum  = sa + sb;
    asum = sum[MAN+1] ? -sum : sum;
    prod = m1 * m2;
    case (sel_op)
      OP_LES:  cbit = (sa < sb);
      OP_GRE:  cbit = (sa > sb);
      OP_EQU:  cbit = (sel_a == sel_b);
      OP_INV:  cbit = ~sel_b[0];
      OP_AND:  cbit = sel_a[0] & sel_b[0];
      OP_OR:   cbit = sel_a[0] | sel_b[0];
      default: cbit = 1'b0;
    endcase
    cres  = {1'b0, {EXP{1'b0}}, 1'b1, {(MAN-2){1'b0}}, cbit};
    dz_ev = 1'b0;
    res   = RES_X;
    case (sel_op)
      OP_NOP:  res = norm_pack(s2, e2, m2);
      OP_LOAD: res = norm_pack(s1, e1, m1);
      OP_ADD:  if (ADD != 0) res = norm_pack(sum[MAN+1], ea + EW'(1), asum[MAN:1]);
      OP_MLT:  if (MLT != 0) res = norm_pack(s1 ^ s2, e1 + e2 + EW'(MAN), prod[2*MAN-1:MAN]);
      OP_DIV: begin
        if (DIV != 0) begin
          if (m2 == '0) begin
            res   = {2'b00, s1 ^ s2, 1'b0, {(EXP-1){1'b1}}, {MAN{1'b1}}};
            dz_ev = 1'b1;
          end else begin
            res = norm_pack(s1 ^ s2, e1 - e2 - EW'(MAN - 1), quo_nxt);
          end
        end
      end
      OP_NEG:  if (NEG != 0) res = norm_pack(~s2, e2, m2);
      OP_ABS:  if (ABS != 0) res = norm_pack(1'b0, e2, m2);
      OP_LES, OP_EQU, OP_INV, OP_AND, OP_GRE, OP_OR:
               if (CMP != 0) res = {2'b00, cres};
      default: res = RES_X;
    endcase
  end

  // Next-state, operand capture, divider sequencing and flag update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    out_d   = out_q;
    fin     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op;
          a_d   = in1;
          b_d   = in2;
          cnt_d = '0;
          rem_d = {2'b00, in1[MAN-1:1]};
          dvd_d = {in1[0], {(MAN-1){1'b0}}};
          quo_d = '0;
          if (op == OP_DIV && DIV != 0 && in2[MAN-1:0] != '0) begin
            state_d = DIVL;
          end else begin
            state_d = FIN;
            fin     = 1'b1;
          end
        end
      end
      DIVL: begin
        rem_d = rem_nxt;
        dvd_d = dvd_q << 1;
        quo_d = quo_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(MAN - 1)) begin
          state_d = FIN;
          fin     = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fin) out_d = res[W-1:0];
    ovf_d = (clr_flags ? 1'b0 : ovf_q) | (fin & res[W+1]);
    unf_d = (clr_flags ? 1'b0 : unf_q) | (fin & res[W]);
    dz_d  = (clr_flags ? 1'b0 : dz_q)  | (fin & dz_ev);
  end

  // Control state, result and flags; reset aborts any divide in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= ZERO_W;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      dz_q    <= dz_d;
    end
  end

  // Latched operands and divider datapath registers
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    a_q   <= a_d;
    b_q   <= b_d;
    rem_q <= rem_d;
    dvd_q <= dvd_d;
    quo_q <= quo_d;
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == FIN);
  assign out  = out_q;
  assign ovf  = ovf_q;
  assign unf  = unf_q;
  assign dz   = dz_q;
endmodule
